// File: rtl/core_mem_arbiter.sv
// Shared banked data memory behind the cores' M stage: round-robin arbiter serving one
// LD/ST every two cycles, with a single-cycle completion strobe back to the winning core.
module core_mem_arbiter #(
    parameter int unsigned NUM_CORES     = 4,
    parameter int unsigned REG_WIDTH     = 8,
    parameter int unsigned CORE_ID_WIDTH = 2
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [2*NUM_CORES-1:0]                         enable_M_all,
    input  logic [NUM_CORES*(CORE_ID_WIDTH+REG_WIDTH)-1:0] addr_M_all,
    input  logic [NUM_CORES*REG_WIDTH-1:0]                 wr_data_M_all,
    output logic [NUM_CORES*REG_WIDTH-1:0]                 rd_data_M_all,
    output logic [NUM_CORES-1:0]                           ready_M_all
);
    localparam int unsigned AddrWidth = CORE_ID_WIDTH + REG_WIDTH;
    localparam int unsigned Depth     = 2 ** REG_WIDTH;
    localparam int unsigned IdxW      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic {StIdle, StResp} state_e;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]      grant_q, grant_d;
    logic                 is_ld_q, is_ld_d;
    logic [REG_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [REG_WIDTH-1:0] mem_q [NUM_CORES][Depth];

    logic [NUM_CORES-1:0]     req;
    logic                     found;
    logic [IdxW-1:0]          win;
    logic [1:0]               win_en;
    logic [AddrWidth-1:0]     win_addr;
    logic [REG_WIDTH-1:0]     win_wdata;
    logic [CORE_ID_WIDTH-1:0] win_bank;
    logic [REG_WIDTH-1:0]     win_word;
    logic                     bank_ok;
    logic                     win_st;
    logic                     mem_we;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            req[i] = |enable_M_all[2*i +: 2];
        end
    end

    // First requester at or after rr_ptr, wrapping modulo NUM_CORES.
    always_comb begin : pick
        int unsigned cand;
        cand  = 0;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            cand = (32'(rr_ptr_q) + k) % NUM_CORES;
            if (!found && req[IdxW'(cand)]) begin
                found = 1'b1;
                win   = IdxW'(cand);
            end
        end
    end

    assign win_en    = enable_M_all[2*win +: 2];
    assign win_addr  = addr_M_all[AddrWidth*win +: AddrWidth];
    assign win_wdata = wr_data_M_all[REG_WIDTH*win +: REG_WIDTH];
    assign win_bank  = win_addr[AddrWidth-1 -: CORE_ID_WIDTH];
    assign win_word  = win_addr[REG_WIDTH-1:0];
    assign bank_ok   = (32'(win_bank) < NUM_CORES);
    // 2'b11 is treated as a load, so only the exact ST encoding may write.
    assign win_st    = (win_en == 2'b10);
    assign mem_we    = (state_q == StIdle) && found && win_st && bank_ok && !reset;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        is_ld_d   = is_ld_q;
        rd_data_d = rd_data_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d   = StResp;
                    grant_d   = win;
                    is_ld_d   = !win_st;
                    rr_ptr_d  = (32'(win) == NUM_CORES - 1) ? '0 : win + 1'b1;
                    rd_data_d = (!win_st && bank_ok) ? mem_q[win_bank][win_word] : '0;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            is_ld_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            is_ld_q   <= is_ld_d;
            rd_data_q <= rd_data_d;
        end
    end

    // The array is deliberately left out of reset so committed stores survive it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[win_bank][win_word] <= win_wdata;
        end
    end

    always_comb begin
        ready_M_all   = '0;
        rd_data_M_all = '0;
        if (state_q == StResp) begin
            ready_M_all[grant_q] = 1'b1;
            if (is_ld_q) begin
                rd_data_M_all[REG_WIDTH*grant_q +: REG_WIDTH] = rd_data_q;
            end
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios plus randomized request rounds checked
// against a transaction-level model (array memory + round-robin pointer).
module tb_core_mem_arbiter;
    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  en;
    logic [39:0] ad;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  rdy;
    logic [5:0]  en3;
    logic [29:0] ad3;
    logic [23:0] wd3;
    logic [23:0] rd3;
    logic [2:0]  rdy3;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] ref_mem   [4][256];
    bit         ref_valid [4][256];
    int         ref_rr;

    always #5 clk = ~clk;

    core_mem_arbiter #(.NUM_CORES(4), .REG_WIDTH(8), .CORE_ID_WIDTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable_M_all  (en),
        .addr_M_all    (ad),
        .wr_data_M_all (wd),
        .rd_data_M_all (rd),
        .ready_M_all   (rdy)
    );

    core_mem_arbiter #(.NUM_CORES(3), .REG_WIDTH(8), .CORE_ID_WIDTH(2)) dut3 (
        .clk           (clk),
        .reset         (reset),
        .enable_M_all  (en3),
        .addr_M_all    (ad3),
        .wr_data_M_all (wd3),
        .rd_data_M_all (rd3),
        .ready_M_all   (rdy3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int c, input logic [1:0] e, input logic [9:0] a,
                           input logic [7:0] d);
        en[2*c +: 2]  = e;
        ad[10*c +: 10] = a;
        wd[8*c +: 8]  = d;
    endtask

    // Called in an IDLE cycle: predicts the winner, checks its one-cycle response,
    // retires it in the model and returns to the next IDLE cycle.
    task automatic serve_one(input string tag, output logic [7:0] got, output int obs);
        int w, b, wo, c;
        logic [1:0]  e;
        logic [31:0] exp_rd, mask;
        w = -1;
        for (int k = 0; k < NC; k++) begin
            c = (ref_rr + k) % NC;
            if (w < 0 && en[2*c +: 2] != 2'b00) w = c;
        end
        got = '0;
        obs = -1;
        check({tag, " idle"}, 32'(rdy), 0);
        step();
        for (int k = 0; k < NC; k++) if (obs < 0 && rdy[k]) obs = k;
        if (w < 0) begin
            check({tag, " none"}, 32'(rdy), 0);
            return;
        end
        e  = en[2*w +: 2];
        b  = int'(ad[10*w+8 +: 2]);
        wo = int'(ad[10*w +: 8]);
        exp_rd = '0;
        mask   = '1;
        if (e == 2'b10) begin
            ref_mem[b][wo]   = wd[8*w +: 8];
            ref_valid[b][wo] = 1'b1;
        end else if (ref_valid[b][wo]) begin
            exp_rd[8*w +: 8] = ref_mem[b][wo];
        end else begin
            mask[8*w +: 8] = '0;
        end
        check({tag, " ready"}, 32'(rdy), 32'(1) << w);
        check({tag, " rdata"}, rd & mask, exp_rd);
        got = rd[8*w +: 8];
        set_req(w, 2'b00, '0, '0);
        ref_rr = (w + 1) % NC;
        step();
    endtask

    task automatic op3(input string tag, input int c, input logic [1:0] e, input logic [9:0] a,
                       input logic [7:0] d, input logic [7:0] exp_rd);
        en3[2*c +: 2]   = e;
        ad3[10*c +: 10] = a;
        wd3[8*c +: 8]   = d;
        step();
        check({tag, " rdy"}, 32'(rdy3), 32'(1) << c);
        check({tag, " rd"}, 32'(rd3), 32'(exp_rd) << (8*c));
        en3[2*c +: 2] = 2'b00;
        step();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        ref_rr = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] g;
        int         o;
        int         p;
        logic [1:0] e;

        reset = 1'b1;
        en = '0; ad = '0; wd = '0;
        en3 = '0; ad3 = '0; wd3 = '0;
        ref_rr = 0;
        step();
        step();
        check("rst ready", 32'(rdy), 0);
        check("rst rdata", rd, 0);
        check("rst ready3", 32'(rdy3), 0);
        reset = 1'b0;

        // Store then load on core 0.
        set_req(0, 2'b10, 10'h105, 8'hA5);
        serve_one("t1 st", g, o);
        set_req(0, 2'b01, 10'h105, 8'h00);
        serve_one("t1 ld", g, o);
        check("t1 ld value", 32'(g), 32'hA5);

        // Each core preloads its own bank, then all load together after reset.
        for (int i = 0; i < NC; i++) begin
            set_req(i, 2'b10, 10'(i * 256 + 'h40), 8'(16 * (i + 1)));
            serve_one("t2 pre", g, o);
        end
        pulse_reset();
        for (int i = 0; i < NC; i++) set_req(i, 2'b01, 10'(i * 256 + 'h40), 8'h00);
        for (int i = 0; i < NC; i++) begin
            serve_one("t2 ld", g, o);
            check("t2 order", o, i);
            check("t2 value", 32'(g), 32'(16 * (i + 1)));
        end

        // Same-address ST/LD race resolved by rr_ptr.
        pulse_reset();
        set_req(1, 2'b01, 10'h040, 8'h00);
        serve_one("t3 rr2", g, o);
        set_req(2, 2'b10, 10'h0FF, 8'h3C);
        set_req(3, 2'b01, 10'h0FF, 8'h00);
        serve_one("t3a first", g, o);
        check("t3a st first", o, 2);
        serve_one("t3a second", g, o);
        check("t3a new val", 32'(g), 32'h3C);
        pulse_reset();
        set_req(2, 2'b01, 10'h040, 8'h00);
        serve_one("t3 rr3", g, o);
        set_req(2, 2'b10, 10'h0FF, 8'h77);
        set_req(3, 2'b01, 10'h0FF, 8'h00);
        serve_one("t3b first", g, o);
        check("t3b old val", 32'(g), 32'h3C);
        serve_one("t3b second", g, o);
        set_req(0, 2'b01, 10'h0FF, 8'h00);
        serve_one("t3b after", g, o);
        check("t3b stored", 32'(g), 32'h77);

        // Core 1 continuous, core 0 back-to-back: strict alternation.
        pulse_reset();
        set_req(0, 2'b01, 10'h105, 8'h00);
        set_req(1, 2'b01, 10'h0FF, 8'h00);
        for (int n = 0; n < 6; n++) begin
            serve_one("t4", g, o);
            check("t4 order", o, n % 2);
            set_req(n % 2, 2'b01, (n % 2 == 0) ? 10'h105 : 10'h0FF, 8'h00);
        end
        set_req(0, 2'b00, '0, '0);
        set_req(1, 2'b00, '0, '0);
        step();
        check("t4 withdrawn", 32'(rdy), 0);
        step();

        // Three-core build: bank 3 is out of range.
        op3("t5 st b0", 0, 2'b10, 10'h010, 8'h11, 8'h00);
        op3("t5 st b1", 0, 2'b10, 10'h110, 8'h22, 8'h00);
        op3("t5 st b2", 0, 2'b10, 10'h210, 8'h33, 8'h00);
        op3("t5 st b3", 1, 2'b10, 10'h310, 8'h5A, 8'h00);
        op3("t5 ld b3", 1, 2'b01, 10'h310, 8'h00, 8'h00);
        op3("t5 ld b0", 0, 2'b01, 10'h010, 8'h00, 8'h11);
        op3("t5 ld b1", 0, 2'b01, 10'h110, 8'h00, 8'h22);
        op3("t5 ld b2", 2, 2'b01, 10'h210, 8'h00, 8'h33);

        // Reset during RESP of a committed store.
        set_req(2, 2'b10, 10'h2AA, 8'h11);
        step();
        check("t6 resp", 32'(rdy), 32'h4);
        reset = 1'b1;
        set_req(2, 2'b00, '0, '0);
        step();
        check("t6 rst ready", 32'(rdy), 0);
        check("t6 rst rdata", rd, 0);
        reset = 1'b0;
        ref_mem[2][8'hAA]   = 8'h11;
        ref_valid[2][8'hAA] = 1'b1;
        ref_rr = 0;
        set_req(0, 2'b01, 10'h105, 8'h00);
        set_req(3, 2'b01, 10'h340, 8'h00);
        serve_one("t6 a", g, o);
        check("t6 rr zero", o, 0);
        serve_one("t6 b", g, o);
        set_req(1, 2'b01, 10'h2AA, 8'h00);
        serve_one("t6 ld", g, o);
        check("t6 kept", 32'(g), 32'h11);

        // Random rounds with address collisions and the illegal 2'b11 encoding.
        for (int r = 0; r < 60; r++) begin
            for (int c = 0; c < NC; c++) begin
                p = $urandom_range(0, 9);
                e = (p < 3) ? 2'b00 : (p < 6) ? 2'b01 : (p < 9) ? 2'b10 : 2'b11;
                set_req(c, e, {2'($urandom_range(0, 3)), 8'($urandom_range(0, 7))},
                        8'($urandom));
            end
            for (int s = 0; s < NC; s++) serve_one("rand", g, o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shared data memory and arbiter sitting directly downstream of the cores' M stage.
- Accepts LD/ST requests from NUM_CORES cores over the per-core memory port (enable_M, addr_M, wr_data_M, rd_data_M, ready_M).
- Serves one access per two cycles with round-robin fairness, from a single-port array of NUM_CORES banks.
- Bank is selected by the core-ID field in the upper address bits; word by the lower REG_WIDTH bits.

Parameters:
- NUM_CORES, 4, number of requesting cores and memory banks.
- REG_WIDTH, 8, data word width and in-bank address width; bank depth = 2^REG_WIDTH.
- CORE_ID_WIDTH, 2, width of the bank-select field; ADDR_WIDTH = CORE_ID_WIDTH + REG_WIDTH.

Ports:
- clk  in  1  single clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- enable_M_all  in  2*NUM_CORES  per core [2i+1:2i]: 2'b01 = LD, 2'b10 = ST, 2'b00 = idle.
- addr_M_all  in  NUM_CORES*ADDR_WIDTH  per core {bank, word}.
- wr_data_M_all  in  NUM_CORES*REG_WIDTH  per core store data.
- rd_data_M_all  out  NUM_CORES*REG_WIDTH  per core load data; valid only while that core's ready bit is 1.
- ready_M_all  out  NUM_CORES  per core completion strobe, one cycle wide.

Behaviour:
- Reset values:
  - state = IDLE, rr_ptr = 0.
  - ready_M_all = 0, rd_data_M_all = 0.
  - Memory array is not cleared.
- Request rule: core i requests when enable bit pair is nonzero. The core holds enable/addr/wr_data stable until it sees its ready bit. 2'b11 is illegal and is served as LD; no write occurs.
- FSM, two states:
  - IDLE:
    - With no request pending, stay in IDLE.
    - Otherwise pick winner g = first requesting index scanning rr_ptr, rr_ptr+1, ... modulo NUM_CORES.
    - At the edge: latch g and the access type.
    - ST writes wr_data[g] to mem[bank][word].
    - LD registers mem[bank][word] into rd_data_r.
    - Set rr_ptr = (g+1) mod NUM_CORES. Go to RESP.
  - RESP:
    - ready_M_all[g] = 1. rd_data_M_all slot g = rd_data_r for LD, 0 for ST. All other slots and ready bits = 0.
    - Next edge always returns to IDLE.
- Latency and throughput:
  - Request visible in cycle t leads to ready in cycle t+1.
  - Peak rate is one access per 2 cycles.
  - The core advances on the ready edge. A new request from the same core is sampled in IDLE at t+2 at the earliest.
- Out-of-range bank (bank >= NUM_CORES):
  - ST is dropped; LD returns 0.
  - Ready is still pulsed normally; no hang.
- Ordering: accesses are applied strictly in grant order. Same-address ST and LD from different cores in the same cycle are resolved by round-robin order.
- Fairness: a continuously requesting core waits at most NUM_CORES-1 grants.
- Non-granted requests are untouched and stay pending; no state is stored for them.
- Request withdrawn while not granted: ignored, no side effects. A request is never withdrawn after grant; behaviour for that case is not guaranteed.
- Reset mid-operation:
  - Reset asserted in RESP forces ready = 0 from the next cycle.
  - A write already committed in IDLE stays in memory.
  - rr_ptr returns to 0.
- Read-after-write: a LD granted after a ST to the same address returns the new data.

Test Plan (NUM_CORES=4, REG_WIDTH=8, CORE_ID_WIDTH=2):
1. Core 0 ST addr 0x105 data 0xA5, then LD 0x105 -> ready_M_all[0] high one cycle after each request; LD returns 0xA5; no other ready bit set.
2. Cores 0..3 all LD at once after reset -> grants in order 0,1,2,3 with ready pulses at cycles t+1, t+3, t+5, t+7; each core gets its own bank's data.
3. Core 2 ST 0x0FF data 0x3C and core 3 LD 0x0FF in the same cycle, rr_ptr = 2 -> ST first; core 3 reads 0x3C. Repeat with rr_ptr = 3 -> core 3 reads the old value.
4. Core 1 requests continuously while core 0 issues back-to-back requests -> core 1 never waits more than one grant; grants alternate 0,1,0,1.
5. Core 1 LD with bank field 3 when NUM_CORES = 3 build -> rd_data = 0x00 and ready pulses. ST to that bank leaves all banks unchanged.
6. Assert reset in RESP cycle of a core 2 ST 0x2AA data 0x11 -> ready drops the next cycle, state IDLE, rr_ptr 0; a later LD 0x2AA returns 0x11.
